mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the single main-memory word port between the I-cache refill engine and the D-cache refill/write-back engine.
- Each grant is a burst of LINE_WORDS word transfers.
- Sits between the two cache controllers (fed by the pipeline's inst_addr and mem_addr paths) and the memory model.
- Sequences the burst address, word counter and per-word handshakes, and signals burst completion back to the owning cache.

Parameters:
- LINE_WORDS, 4, words per cache line. Power of 2, minimum 2.
- IDX_W, 2, word-index width. Must equal log2(LINE_WORDS).

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- ic_req  in  1  I-cache burst request (read only); held until ic_done
- ic_addr  in  32  I-cache line address; bits [IDX_W+1:0] ignored
- ic_rdata  out  32  read word to I-cache
- ic_rvalid  out  1  ic_rdata valid this cycle
- ic_word  out  IDX_W  index of the word in transfer
- ic_done  out  1  one-cycle burst-complete pulse
- dc_req  in  1  D-cache burst request; held until dc_done
- dc_we  in  1  1 = write-back burst, 0 = refill
- dc_addr  in  32  D-cache line address; low bits ignored
- dc_wdata  in  32  write word; D-cache drives it combinationally from dc_word
- dc_rdata  out  32  read word to D-cache
- dc_rvalid  out  1  dc_rdata valid this cycle (refill only)
- dc_word  out  IDX_W  index of the word in transfer
- dc_done  out  1  one-cycle burst-complete pulse
- mem_req  out  1  word request to memory
- mem_we  out  1  word write enable
- mem_addr  out  32  word byte address
- mem_wdata  out  32  write data
- mem_rdata  in  32  read data
- mem_ready  in  1  word transfer complete this cycle
- busy  out  1  state != IDLE

Behaviour:
- States: IDLE, IC_BURST, DC_BURST, DONE.
- Reset (rst_n=0 at clock edge): state=IDLE, cnt=0, owner/addr/we registers cleared.
  - All outputs 0 after reset: mem_req, mem_we, mem_addr, ic_/dc_ rvalid/done/word, busy.
- Reset mid-burst: burst is abandoned, mem_req drops at the same edge, no done pulse is generated. Memory must tolerate the abandoned request.
- IDLE:
  - dc_req=1 → DC_BURST.
  - Otherwise ic_req=1 → IC_BURST.
  - At the transition, latch line address {addr[31:IDX_W+2]} and dc_we (0 for I-cache); cnt=0.
  - Grant takes effect the cycle after the request is seen. This is one cycle of arbitration latency.
- xx_BURST:
  - mem_req=1, mem_addr={line, cnt, 2'b00}.
  - mem_we = latched we. mem_wdata = dc_wdata during a D-cache write, else 0.
  - xx_word = cnt.
  - When mem_ready=1:
    - Owner's rvalid=1 combinationally and rdata=mem_rdata, reads only. For writes, rvalid stays 0.
    - cnt increments.
    - If cnt==LINE_WORDS-1: cnt wraps to 0 and state → DONE.
  - mem_ready=0: hold address, data and cnt. There is no timeout.
  - Requester deasserting req mid-burst is ignored; the burst completes.
  - The other requester's req is ignored until IDLE.
- DONE:
  - Owner's done=1 for exactly this cycle. mem_req=0. Requests are ignored.
  - Next cycle → IDLE.
  - The requester must drop req in the cycle after done. A req still high in IDLE is treated as a new burst.
- Minimum burst time: LINE_WORDS cycles with mem_ready held 1, plus 1 cycle DONE and 1 cycle IDLE.
- Only the owner's outputs toggle. The non-owner's rvalid, done and word stay 0.
- Both requesting in IDLE (base priority): D-cache wins. The MEM-stage miss is older than the IF miss.

Optional Feature:
- Macro: ARB_RR_EN.
- Defined: round-robin arbitration.
  - A last_owner register (reset value = I-cache) is updated on every grant.
  - When both request in IDLE, the requester that is not last_owner is granted.
  - A single requester is always granted.
- Undefined: fixed D-cache priority; no last_owner register.

Test Plan:
- I-cache only, ic_addr=0x0000_1234, mem_ready=1 constantly, mem_rdata=addr → mem_addr sequence 0x1230, 0x1234, 0x1238, 0x123C. ic_rvalid on 4 consecutive cycles with ic_word 0..3. ic_done 1 cycle later; busy for 5 cycles.
- D-cache write-back, dc_addr=0x0000_0040, dc_wdata=0xA0+dc_word, mem_ready every 3rd cycle → mem_we=1. Writes 0xA0..0xA3 to 0x40..0x4C. Address holds while mem_ready=0. dc_rvalid never 1. dc_done once.
- ic_req and dc_req rise together:
  - Base: DC_BURST first, then IC_BURST after DONE+IDLE.
  - ARB_RR_EN: D-cache first (last_owner reset = I-cache). A second simultaneous pair is granted to the I-cache.
- ic_req dropped after word 1 → burst still completes all 4 words and ic_done pulses.
- rst_n=0 during word 2 of a D-cache refill → next cycle mem_req=0, busy=0, dc_done never pulses. A new ic_req is then granted normally with cnt starting at 0.
- Back-to-back: ic_req held high through the DONE cycle and low in the following cycle → exactly one burst. If held high one cycle longer → a second burst starts.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Shares the main-memory word port between I-cache and D-cache line bursts.
// Define ARB_RR_EN for round-robin arbitration; default is fixed D-cache priority.
module mem_bus_arbiter #(
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned IDX_W      = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ic_req,
    input  logic [31:0]      ic_addr,
    output logic [31:0]      ic_rdata,
    output logic             ic_rvalid,
    output logic [IDX_W-1:0] ic_word,
    output logic             ic_done,
    input  logic             dc_req,
    input  logic             dc_we,
    input  logic [31:0]      dc_addr,
    input  logic [31:0]      dc_wdata,
    output logic [31:0]      dc_rdata,
    output logic             dc_rvalid,
    output logic [IDX_W-1:0] dc_word,
    output logic             dc_done,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_ready,
    output logic             busy
);

    localparam int unsigned LineW = 30 - IDX_W;

    typedef enum logic [1:0] {StIdle, StIcBurst, StDcBurst, StDone} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [LineW-1:0] line_q, line_d;
    logic             we_q, we_d;
    logic             owner_dc_q, owner_dc_d;
    logic             grant_dc;
    logic             in_burst;
    logic             last_word;

    // Word-offset bits of the line addresses carry no information here.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{ic_addr[IDX_W+1:0], dc_addr[IDX_W+1:0]};

`ifdef ARB_RR_EN
    logic last_dc_q, last_dc_d;

    // On a tie the requester that did not own the previous grant wins.
    assign grant_dc = dc_req && (!ic_req || !last_dc_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_dc_q <= 1'b0;
        end else begin
            last_dc_q <= last_dc_d;
        end
    end

    always_comb begin
        last_dc_d = last_dc_q;
        if (state_q == StIdle && (dc_req || ic_req)) begin
            last_dc_d = grant_dc;
        end
    end
`else
    // The MEM-stage miss is older than the IF miss, so the D-cache wins ties.
    assign grant_dc = dc_req;
`endif

    assign in_burst  = (state_q == StIcBurst) || (state_q == StDcBurst);
    assign last_word = (cnt_q == IDX_W'(LINE_WORDS - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            line_q     <= '0;
            we_q       <= 1'b0;
            owner_dc_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            line_q     <= line_d;
            we_q       <= we_d;
            owner_dc_q <= owner_dc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        line_d     = line_q;
        we_d       = we_q;
        owner_dc_d = owner_dc_q;
        case (state_q)
            StIdle: begin
                if (dc_req || ic_req) begin
                    state_d    = grant_dc ? StDcBurst : StIcBurst;
                    owner_dc_d = grant_dc;
                    line_d     = grant_dc ? dc_addr[31:IDX_W+2] : ic_addr[31:IDX_W+2];
                    we_d       = grant_dc && dc_we;
                    cnt_d      = '0;
                end
            end
            StIcBurst, StDcBurst: begin
                if (mem_ready) begin
                    cnt_d = cnt_q + IDX_W'(1);
                    if (last_word) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        mem_req   = in_burst;
        mem_we    = in_burst && we_q;
        mem_addr  = in_burst ? {line_q, cnt_q, 2'b00} : 32'h0;
        mem_wdata = (state_q == StDcBurst && we_q) ? dc_wdata : 32'h0;
        ic_rvalid = (state_q == StIcBurst) && mem_ready;
        dc_rvalid = (state_q == StDcBurst) && mem_ready && !we_q;
        ic_rdata  = ic_rvalid ? mem_rdata : 32'h0;
        dc_rdata  = dc_rvalid ? mem_rdata : 32'h0;
        ic_word   = (state_q == StIcBurst) ? cnt_q : '0;
        dc_word   = (state_q == StDcBurst) ? cnt_q : '0;
        ic_done   = (state_q == StDone) && !owner_dc_q;
        dc_done   = (state_q == StDone) && owner_dc_q;
        busy      = (state_q != StIdle);
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: single bursts, ties, early req drop, reset, back-to-back.
// Tie-break expectations follow ARB_RR_EN when the bench is built with it defined.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ic_req = 1'b0;
    logic [31:0] ic_addr = 32'h0;
    logic [31:0] ic_rdata;
    logic        ic_rvalid;
    logic [1:0]  ic_word;
    logic        ic_done;
    logic        dc_req = 1'b0;
    logic        dc_we = 1'b0;
    logic [31:0] dc_addr = 32'h0;
    logic [31:0] dc_wdata;
    logic [31:0] dc_rdata;
    logic        dc_rvalid;
    logic [1:0]  dc_word;
    logic        dc_done;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready = 1'b0;
    logic        busy;

    int checks = 0;
    int failures = 0;

    // Memory returns its address as data; the D-cache supplies 0xA0 + word index.
    assign mem_rdata = mem_addr;
    assign dc_wdata  = 32'hA0 + 32'(dc_word);

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .LINE_WORDS(4),
        .IDX_W     (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ic_req   (ic_req),
        .ic_addr  (ic_addr),
        .ic_rdata (ic_rdata),
        .ic_rvalid(ic_rvalid),
        .ic_word  (ic_word),
        .ic_done  (ic_done),
        .dc_req   (dc_req),
        .dc_we    (dc_we),
        .dc_addr  (dc_addr),
        .dc_wdata (dc_wdata),
        .dc_rdata (dc_rdata),
        .dc_rvalid(dc_rvalid),
        .dc_word  (dc_word),
        .dc_done  (dc_done),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .busy     (busy)
    );

    // Start a cycle: inputs driven after this are captured at the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        rst_n = 1'b0; ic_req = 1'b0; dc_req = 1'b0; dc_we = 1'b0;
        mem_ready = 1'b0; ic_addr = 32'h0; dc_addr = 32'h0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [43:0] got;
        step();
        rst_n = 1'b0; dc_req = 1'b1; ic_req = 1'b1; mem_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            @(negedge clk);
            got = {mem_req, mem_we, mem_addr, ic_rvalid, ic_done, ic_word,
                   dc_rvalid, dc_done, dc_word, busy};
            checks++;
            if (got !== 44'h0) begin
                failures++;
                $display("FAIL reset_outputs cycle=%0d got=%h expected 0", i, got);
            end
        end
        step();
        rst_n = 1'b1; dc_req = 1'b0; ic_req = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL reset_release busy=%b mem_req=%b expected 0 0", busy, mem_req);
        end
    endtask

    task automatic test_ic_read();
        logic [31:0] exp_addr;
        int busy_cnt;
        int done_cnt;
        busy_cnt = 0;
        done_cnt = 0;
        step();
        ic_req = 1'b1; ic_addr = 32'h0000_1234; mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL ic_grant_latency busy=%b mem_req=%b expected 0 0", busy, mem_req);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            @(negedge clk);
            exp_addr = 32'h0000_1230 + 32'(4 * i);
            checks++;
            if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== exp_addr) begin
                failures++;
                $display("FAIL ic_mem_addr word=%0d req=%b we=%b addr=%h expected 1 0 %h",
                         i, mem_req, mem_we, mem_addr, exp_addr);
            end
            checks++;
            if (ic_rvalid !== 1'b1 || ic_word !== 2'(i) || ic_rdata !== exp_addr) begin
                failures++;
                $display("FAIL ic_read_word word=%0d rvalid=%b idx=%0d rdata=%h expected 1 %0d %h",
                         i, ic_rvalid, ic_word, ic_rdata, i, exp_addr);
            end
            checks++;
            if ({dc_rvalid, dc_done, dc_word} !== 4'b0) begin
                failures++;
                $display("FAIL ic_nonowner_quiet got=%b expected 0000",
                         {dc_rvalid, dc_done, dc_word});
            end
            busy_cnt += int'(busy);
        end
        step();
        ic_req = 1'b0;
        @(negedge clk);
        checks++;
        if (ic_done !== 1'b1 || mem_req !== 1'b0 || ic_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL ic_done_cycle done=%b mem_req=%b rvalid=%b expected 1 0 0",
                     ic_done, mem_req, ic_rvalid);
        end
        busy_cnt += int'(busy);
        done_cnt += int'(ic_done);
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            busy_cnt += int'(busy);
            done_cnt += int'(ic_done);
        end
        checks++;
        if (busy_cnt != 5 || done_cnt != 1) begin
            failures++;
            $display("FAIL ic_busy_done_counts busy=%0d done=%0d expected 5 1", busy_cnt, done_cnt);
        end
    endtask

    task automatic test_dc_write();
        int w;
        int rv_cnt;
        int done_cnt;
        int other_cnt;
        rv_cnt = 0;
        done_cnt = 0;
        other_cnt = 0;
        step();
        dc_req = 1'b1; dc_we = 1'b1; dc_addr = 32'h0000_0040; mem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL dc_grant_latency busy=%b expected 0", busy);
        end
        for (int k = 0; k < 12; k++) begin
            step();
            mem_ready = (k % 3 == 2);
            @(negedge clk);
            w = k / 3;
            checks++;
            if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h40 + 32'(4 * w) ||
                mem_wdata !== 32'hA0 + 32'(w) || dc_word !== 2'(w)) begin
                failures++;
                $display("FAIL dc_write_beat k=%0d req=%b we=%b addr=%h wdata=%h idx=%0d expected 1 1 %h %h %0d",
                         k, mem_req, mem_we, mem_addr, mem_wdata, dc_word,
                         32'h40 + 32'(4 * w), 32'hA0 + 32'(w), w);
            end
            rv_cnt    += int'(dc_rvalid);
            done_cnt  += int'(dc_done);
            other_cnt += int'(ic_rvalid) + int'(ic_done) + int'(ic_word != 2'd0);
        end
        step();
        dc_req = 1'b0; dc_we = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (dc_done !== 1'b1 || mem_req !== 1'b0 || mem_we !== 1'b0) begin
            failures++;
            $display("FAIL dc_done_cycle done=%b mem_req=%b mem_we=%b expected 1 0 0",
                     dc_done, mem_req, mem_we);
        end
        done_cnt += int'(dc_done);
        for (int i = 0; i < 2; i++) begin
            step();
            @(negedge clk);
            done_cnt += int'(dc_done);
        end
        checks++;
        if (rv_cnt != 0 || done_cnt != 1 || other_cnt != 0) begin
            failures++;
            $display("FAIL dc_write_counts rvalid=%0d done=%0d ic_activity=%0d expected 0 1 0",
                     rv_cnt, done_cnt, other_cnt);
        end
    endtask

    task automatic test_both();
        logic        rr;
        logic        own_dc;
        logic        own1_dc;
        logic        act;
        int          seg;
        int          pos;
        logic [31:0] e_addr;
        logic [41:0] got;
        logic [41:0] exp;
`ifdef ARB_RR_EN
        rr = 1'b1;
`else
        rr = 1'b0;
`endif
        own1_dc = !rr;
        do_reset();
        for (int c = 0; c < 19; c++) begin
            step();
            if (c == 0) begin
                ic_req = 1'b1; dc_req = 1'b1; dc_we = 1'b0; mem_ready = 1'b1;
                ic_addr = 32'h0000_2000; dc_addr = 32'h0000_3004;
            end
            if (c == 11) begin
                if (own1_dc) dc_req = 1'b0;
                else ic_req = 1'b0;
            end
            if (c == 17) begin
                ic_req = 1'b0; dc_req = 1'b0;
            end
            @(negedge clk);
            seg    = c / 6;
            pos    = c % 6;
            own_dc = (seg == 0) ? 1'b1 : (seg == 1) ? own1_dc : !own1_dc;
            act    = (pos >= 1) && (pos <= 4) && (seg < 3);
            e_addr = act ? ((own_dc ? 32'h3000 : 32'h2000) + 32'(4 * (pos - 1))) : 32'h0;
            exp = {act, e_addr, act && !own_dc, act && own_dc,
                   pos == 5 && !own_dc, pos == 5 && own_dc,
                   (act && !own_dc) ? 2'(pos - 1) : 2'd0,
                   (act && own_dc) ? 2'(pos - 1) : 2'd0,
                   pos != 0};
            got = {mem_req, mem_addr, ic_rvalid, dc_rvalid, ic_done, dc_done,
                   ic_word, dc_word, busy};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL tie_arbitration cycle=%0d got=%h expected %h", c, got, exp);
            end
        end
    endtask

    task automatic test_ic_drop();
        logic [37:0] got;
        logic [37:0] exp;
        logic        act;
        step();
        ic_req = 1'b1; ic_addr = 32'h0000_0508; mem_ready = 1'b1;
        @(negedge clk);
        for (int c = 1; c < 8; c++) begin
            step();
            if (c == 3) ic_req = 1'b0;
            @(negedge clk);
            act = (c >= 1) && (c <= 4);
            exp = {act, act ? 2'(c - 1) : 2'd0, c == 5,
                   act ? 32'h500 + 32'(4 * (c - 1)) : 32'h0, c <= 5};
            got = {ic_rvalid, ic_word, ic_done, mem_addr, busy};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL ic_req_dropped cycle=%0d got=%h expected %h", c, got, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        int dc_done_cnt;
        dc_done_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            case (c)
                0: begin
                    dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h0000_0800; mem_ready = 1'b1;
                end
                3: begin
                    rst_n = 1'b0; dc_req = 1'b0;
                end
                4: rst_n = 1'b1;
                5: begin
                    ic_req = 1'b1; ic_addr = 32'h0000_090C;
                end
                10: ic_req = 1'b0;
                default: ;
            endcase
            @(negedge clk);
            if (c >= 3) dc_done_cnt += int'(dc_done);
            if (c == 3) begin
                checks++;
                if (dc_word !== 2'd2 || dc_rvalid !== 1'b1 || mem_addr !== 32'h808) begin
                    failures++;
                    $display("FAIL rst_mid_word2 idx=%0d rvalid=%b addr=%h expected 2 1 00000808",
                             dc_word, dc_rvalid, mem_addr);
                end
            end
            if (c == 4 || c == 5) begin
                checks++;
                if (mem_req !== 1'b0 || busy !== 1'b0 || dc_word !== 2'd0) begin
                    failures++;
                    $display("FAIL rst_mid_abandon cycle=%0d mem_req=%b busy=%b idx=%0d expected 0 0 0",
                             c, mem_req, busy, dc_word);
                end
            end
            if (c == 6) begin
                checks++;
                if (mem_addr !== 32'h900 || ic_word !== 2'd0 || ic_rvalid !== 1'b1) begin
                    failures++;
                    $display("FAIL rst_mid_regrant addr=%h idx=%0d rvalid=%b expected 00000900 0 1",
                             mem_addr, ic_word, ic_rvalid);
                end
            end
            if (c == 10) begin
                checks++;
                if (ic_done !== 1'b1) begin
                    failures++;
                    $display("FAIL rst_mid_ic_done done=%b expected 1", ic_done);
                end
            end
        end
        checks++;
        if (dc_done_cnt != 0) begin
            failures++;
            $display("FAIL rst_mid_no_dc_done count=%0d expected 0", dc_done_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int done_cnt;
        for (int mode = 0; mode < 2; mode++) begin
            done_cnt = 0;
            for (int c = 0; c < 13; c++) begin
                step();
                if (c == 0) begin
                    ic_req = 1'b1; ic_addr = 32'h0000_1000; mem_ready = 1'b1;
                end
                if (c == 6 + mode) ic_req = 1'b0;
                @(negedge clk);
                done_cnt += int'(ic_done);
                if (c == 7) begin
                    checks++;
                    if (busy !== 1'(mode) || mem_addr !== (mode == 1 ? 32'h1000 : 32'h0)) begin
                        failures++;
                        $display("FAIL b2b_second_grant mode=%0d busy=%b addr=%h expected %0d %h",
                                 mode, busy, mem_addr, mode, mode == 1 ? 32'h1000 : 32'h0);
                    end
                end
            end
            checks++;
            if (done_cnt != 1 + mode || busy !== 1'b0) begin
                failures++;
                $display("FAIL b2b_burst_count mode=%0d done=%0d busy=%b expected %0d 0",
                         mode, done_cnt, busy, 1 + mode);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ic_read();
        test_dc_write();
        test_both();
        test_ic_drop();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
